// File: rtl/bit_serial_tx.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready handshake and
// shifts it out LSB-first on tx_d with a frame strobe and optional even parity.
module bit_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             tx_d,
    output logic             tx_frame,
    output logic             tx_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             par, par_nxt;
    logic             tx_d_nxt, tx_frame_nxt, tx_done_nxt, load_ready_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            tx_d       <= 1'b0;
            tx_frame   <= 1'b0;
            tx_done    <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            cnt        <= cnt_nxt;
            par        <= par_nxt;
            tx_d       <= tx_d_nxt;
            tx_frame   <= tx_frame_nxt;
            tx_done    <= tx_done_nxt;
            load_ready <= load_ready_nxt;
        end
    end

    // cnt holds the number of bits still to present after the one on tx_d now;
    // par accumulates every bit as it is presented, so it is complete at cnt == 0.
    always_comb begin
        state_nxt      = state;
        sreg_nxt       = sreg;
        cnt_nxt        = cnt;
        par_nxt        = par;
        tx_d_nxt       = 1'b0;
        tx_frame_nxt   = 1'b0;
        tx_done_nxt    = 1'b0;
        load_ready_nxt = 1'b0;

        case (state)
            IDLE: begin
                load_ready_nxt = 1'b1;
                if (load_valid && load_ready) begin
                    sreg_nxt       = load_data;
                    cnt_nxt        = CW'(WIDTH - 1);
                    par_nxt        = load_data[0];
                    state_nxt      = SHIFT;
                    tx_d_nxt       = load_data[0];
                    tx_frame_nxt   = 1'b1;
                    load_ready_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    sreg_nxt     = sreg >> 1;
                    cnt_nxt      = cnt - 1'b1;
                    tx_d_nxt     = sreg[1];
                    par_nxt      = par ^ sreg[1];
                    tx_frame_nxt = 1'b1;
                end else if (PARITY_EN) begin
                    state_nxt    = PARITY;
                    tx_d_nxt     = par;
                    tx_frame_nxt = 1'b1;
                end else begin
                    state_nxt      = IDLE;
                    tx_done_nxt    = 1'b1;
                    load_ready_nxt = 1'b1;
                end
            end
            PARITY: begin
                state_nxt      = IDLE;
                tx_done_nxt    = 1'b1;
                load_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt      = IDLE;
                load_ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serial_tx.sv
// Directed bench for bit_serial_tx: an 8-bit parity instance and a 4-bit no-parity instance.
module tb_bit_serial_tx;

    logic       clk = 1'b0;
    logic       reset8, reset4;
    logic       valid8, ready8, txd8, frame8, done8;
    logic [7:0] data8;
    logic       valid4, ready4, txd4, frame4, done4;
    logic [3:0] data4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_tx #(.WIDTH(8), .PARITY_EN(1)) dut8 (
        .clk(clk), .reset(reset8), .load_valid(valid8), .load_ready(ready8),
        .load_data(data8), .tx_d(txd8), .tx_frame(frame8), .tx_done(done8)
    );

    bit_serial_tx #(.WIDTH(4), .PARITY_EN(0)) dut4 (
        .clk(clk), .reset(reset4), .load_valid(valid4), .load_ready(ready4),
        .load_data(data4), .tx_d(txd4), .tx_frame(frame4), .tx_done(done4)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] bits;   // expected tx_d in cycles 1..8, bit k = cycle k+1
        logic       par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one word on dut8 and checks every cycle of the frame plus the idle after it.
    task automatic frame8_run(input logic [7:0] d, input logic [7:0] bits, input logic p, input string tag);
        chk({tag, " ready before"}, ready8, 1);
        valid8 = 1'b1;
        data8  = d;
        @(posedge clk); #1;
        valid8 = 1'b0;
        data8  = ~d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d", tag, k), txd8, bits[k]);
            chk($sformatf("%s frame%0d", tag, k), frame8, 1);
            chk($sformatf("%s ready%0d", tag, k), ready8, 0);
            chk($sformatf("%s done%0d", tag, k), done8, 0);
        end
        @(negedge clk);
        chk({tag, " parity"}, txd8, p);
        chk({tag, " parity frame"}, frame8, 1);
        chk({tag, " parity done"}, done8, 0);
        @(negedge clk);
        chk({tag, " done"}, done8, 1);
        chk({tag, " done frame"}, frame8, 0);
        chk({tag, " done txd"}, txd8, 0);
        chk({tag, " done ready"}, ready8, 1);
        @(negedge clk);
        chk({tag, " done pulse end"}, done8, 0);
        chk({tag, " idle frame"}, frame8, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{data: 8'hA5, bits: 8'hA5, par: 1'b0};
        tbl[1] = '{data: 8'h00, bits: 8'h00, par: 1'b0};
        tbl[2] = '{data: 8'h01, bits: 8'h01, par: 1'b1};
        tbl[3] = '{data: 8'h7F, bits: 8'h7F, par: 1'b1};
        tbl[4] = '{data: 8'hC3, bits: 8'hC3, par: 1'b0};

        // Reset held with load_valid high: nothing may start.
        reset8 = 1'b0; reset4 = 1'b0;
        valid8 = 1'b1; data8 = 8'hA5;
        valid4 = 1'b0; data4 = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst ready c%0d", c), ready8, 1);
            chk($sformatf("rst txd c%0d", c), txd8, 0);
            chk($sformatf("rst frame c%0d", c), frame8, 0);
            chk($sformatf("rst done c%0d", c), done8, 0);
        end
        valid8 = 1'b0;
        reset8 = 1'b1; reset4 = 1'b1;
        @(negedge clk);
        chk("post-rst frame", frame8, 0);
        chk("post-rst ready4", ready4, 1);

        for (int i = 0; i < 5; i++)
            frame8_run(tbl[i].data, tbl[i].bits, tbl[i].par, $sformatf("vec%0d", i));

        // Back-to-back: 0x01 then 0xFF with load_valid held high.
        valid8 = 1'b1; data8 = 8'h01;
        @(posedge clk); #1;
        data8 = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b f1 bit%0d", k), txd8, (k == 0) ? 1 : 0);
            chk($sformatf("b2b f1 frame%0d", k), frame8, 1);
        end
        @(negedge clk);
        chk("b2b f1 parity", txd8, 1);
        @(negedge clk);
        chk("b2b f1 done", done8, 1);
        chk("b2b gap frame", frame8, 0);
        chk("b2b gap ready", ready8, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) valid8 = 1'b0;
            chk($sformatf("b2b f2 bit%0d", k), txd8, 1);
            chk($sformatf("b2b f2 frame%0d", k), frame8, 1);
            chk($sformatf("b2b f2 done%0d", k), done8, 0);
        end
        @(negedge clk);
        chk("b2b f2 parity", txd8, 0);
        chk("b2b f2 parity frame", frame8, 1);
        @(negedge clk);
        chk("b2b f2 done", done8, 1);
        @(negedge clk);
        chk("b2b no third frame", frame8, 0);

        // Busy ignore: 0x3C offered in cycle 4 of a 0x81 frame.
        valid8 = 1'b1; data8 = 8'h81;
        @(posedge clk); #1;
        valid8 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("busy bit c%0d", c), txd8, (c == 1 || c == 8) ? 1 : 0);
            chk($sformatf("busy ready c%0d", c), ready8, 0);
            if (c == 4) begin valid8 = 1'b1; data8 = 8'h3C; end
            if (c == 5) valid8 = 1'b0;
        end
        @(negedge clk);
        chk("busy parity", txd8, 0);
        chk("busy parity ready", ready8, 0);
        @(negedge clk);
        chk("busy done", done8, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("busy no 2nd frame c%0d", c), frame8, 0);
        end

        // Reset in cycle 5 of a 0xF0 frame (tx_d is 1 there).
        valid8 = 1'b1; data8 = 8'hF0;
        @(posedge clk); #1;
        valid8 = 1'b0;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        chk("midrst txd before", txd8, 1);
        chk("midrst frame before", frame8, 1);
        reset8 = 1'b0;
        #1;
        chk("midrst frame async", frame8, 0);
        chk("midrst txd async", txd8, 0);
        chk("midrst ready async", ready8, 1);
        chk("midrst done async", done8, 0);
        @(negedge clk);
        reset8 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("midrst no done c%0d", c), done8, 0);
            chk($sformatf("midrst idle frame c%0d", c), frame8, 0);
        end
        frame8_run(8'h0F, 8'h0F, 1'b0, "after-rst");

        // No-parity 4-bit instance, 0x7.
        valid4 = 1'b1; data4 = 4'h7;
        @(posedge clk); #1;
        valid4 = 1'b0; data4 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("w4 bit%0d", k), txd4, (k < 3) ? 1 : 0);
            chk($sformatf("w4 frame%0d", k), frame4, 1);
            chk($sformatf("w4 done%0d", k), done4, 0);
        end
        @(negedge clk);
        chk("w4 done", done4, 1);
        chk("w4 done frame", frame4, 0);
        chk("w4 done txd", txd4, 0);
        chk("w4 done ready", ready4, 1);
        @(negedge clk);
        chk("w4 done pulse end", done4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
